// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use / branch-after-load stalls, redirect flushes,
// memory-wait freeze, plus wrap-around stall and flush event counters.
module hazard_stall_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFID_RS,
    input  logic [4:0]       IFID_RT,
    input  logic             IFID_UsesRT,
    input  logic             IFID_Branch,
    input  logic             IFID_Jump,
    input  logic             BranchTaken,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       WriteReg,
    input  logic             EXMEM_MemRead,
    input  logic [4:0]       EXMEM_RD,
    input  logic             MemWait,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             PipeHold,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        BSTALL = 2'b01
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic ex_match, mem_match;
    logic load_use, br_load_ex, br_load_mem;
    logic stall, redirect;
    logic do_stall, do_redir;

    // $zero is never a real dependence
    assign ex_match = (WriteReg != 5'd0) &&
                      ((WriteReg == IFID_RS) ||
                       (IFID_UsesRT && (WriteReg == IFID_RT)));
    assign mem_match = (EXMEM_RD != 5'd0) &&
                       ((EXMEM_RD == IFID_RS) ||
                        (IFID_UsesRT && (EXMEM_RD == IFID_RT)));

    assign load_use    = IDEX_MemRead && IDEX_RegWrite && ex_match;
    assign br_load_ex  = IFID_Branch && load_use;
    assign br_load_mem = IFID_Branch && EXMEM_MemRead && mem_match;

    assign stall    = load_use || br_load_mem || (state_q == BSTALL);
    assign redirect = (IFID_Branch && BranchTaken) || IFID_Jump;

    assign do_stall = !MemWait && stall;
    assign do_redir = !MemWait && !stall && redirect;

    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        PipeHold    = 1'b0;
        if (!rst_n) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else begin
            unique case (1'b1)
                MemWait: begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    PipeHold   = 1'b1;
                end
                do_stall: begin
                    PCWrite     = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                end
                do_redir: begin
                    IFID_Flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (!MemWait) begin
            case (state_q)
                RUN:     state_d = br_load_ex ? BSTALL : RUN;
                BSTALL:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (do_stall)
                stall_cnt <= stall_cnt + 1'b1;
            if (do_redir)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign StallCount = stall_cnt;
    assign FlushCount = flush_cnt;
    assign State      = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: stalls, redirects, filtering,
// memory wait, counter wrap and reset out of BSTALL.
module tb_hazard_stall_controller;

    logic        clk;
    logic        rst_n;
    logic [4:0]  IFID_RS, IFID_RT;
    logic        IFID_UsesRT, IFID_Branch, IFID_Jump, BranchTaken;
    logic        IDEX_MemRead, IDEX_RegWrite;
    logic [4:0]  WriteReg;
    logic        EXMEM_MemRead;
    logic [4:0]  EXMEM_RD;
    logic        MemWait;
    logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeHold;
    logic [15:0] StallCount, FlushCount;
    logic [1:0]  State;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [15:0] exp_flush = 16'd0;

    hazard_stall_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_RS(IFID_RS), .IFID_RT(IFID_RT),
        .IFID_UsesRT(IFID_UsesRT), .IFID_Branch(IFID_Branch),
        .IFID_Jump(IFID_Jump), .BranchTaken(BranchTaken),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
        .WriteReg(WriteReg), .EXMEM_MemRead(EXMEM_MemRead),
        .EXMEM_RD(EXMEM_RD), .MemWait(MemWait),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
        .PipeHold(PipeHold), .StallCount(StallCount),
        .FlushCount(FlushCount), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        IFID_RS = 5'd0; IFID_RT = 5'd0; IFID_UsesRT = 1'b0;
        IFID_Branch = 1'b0; IFID_Jump = 1'b0; BranchTaken = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; WriteReg = 5'd0;
        EXMEM_MemRead = 1'b0; EXMEM_RD = 5'd0; MemWait = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if ({PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeHold} !== 5'b00110) begin errors++; $display("FAIL reset_outputs got %b want 00110", {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeHold}); end
        step(); step();
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", State); end
        checks++; if ({StallCount, FlushCount} !== 32'd0) begin errors++; $display("FAIL reset_counters got %h/%h want 0/0", StallCount, FlushCount); end
        rst_n = 1'b1;
        #1;
        checks++; if ({PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble} !== 4'b1100) begin errors++; $display("FAIL run_outputs got %b want 1100", {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble}); end
    endtask

    task automatic test_load_use();
        idle();
        IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; WriteReg = 5'd2;
        IFID_RS = 5'd2; IFID_RT = 5'd4; IFID_UsesRT = 1'b1;
        #1;
        checks++; if ({PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush} !== 4'b0010) begin errors++; $display("FAIL loaduse_stall got %b want 0010", {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush}); end
        step();
        exp_stall++;
        IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; WriteReg = 5'd0;
        EXMEM_MemRead = 1'b1; EXMEM_RD = 5'd2;
        #1;
        checks++; if ({PCWrite, IDEX_Bubble} !== 2'b10) begin errors++; $display("FAIL loaduse_release got %b want 10", {PCWrite, IDEX_Bubble}); end
        checks++; if (StallCount !== exp_stall) begin errors++; $display("FAIL loaduse_count got %0d want %0d", StallCount, exp_stall); end
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL loaduse_state got %b want 00", State); end
        step();
    endtask

    task automatic test_branch_load();
        idle();
        IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; WriteReg = 5'd2;
        IFID_Branch = 1'b1; IFID_RS = 5'd2; IFID_RT = 5'd5;
        IFID_UsesRT = 1'b1; BranchTaken = 1'b1;
        #1;
        checks++; if ({PCWrite, IDEX_Bubble, IFID_Flush} !== 3'b010) begin errors++; $display("FAIL brload_c1 got %b want 010", {PCWrite, IDEX_Bubble, IFID_Flush}); end
        step();
        exp_stall++;
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL brload_state1 got %b want 01", State); end
        IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; WriteReg = 5'd0;
        EXMEM_MemRead = 1'b1; EXMEM_RD = 5'd2;
        #1;
        checks++; if ({PCWrite, IDEX_Bubble, IFID_Flush} !== 3'b010) begin errors++; $display("FAIL brload_c2 got %b want 010", {PCWrite, IDEX_Bubble, IFID_Flush}); end
        step();
        exp_stall++;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL brload_state2 got %b want 00", State); end
        EXMEM_MemRead = 1'b0; EXMEM_RD = 5'd0;
        #1;
        checks++; if ({PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush} !== 4'b1101) begin errors++; $display("FAIL brload_redirect got %b want 1101", {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush}); end
        step();
        exp_flush++;
        checks++; if (StallCount !== exp_stall) begin errors++; $display("FAIL brload_stalls got %0d want %0d", StallCount, exp_stall); end
        checks++; if (FlushCount !== exp_flush) begin errors++; $display("FAIL brload_flushes got %0d want %0d", FlushCount, exp_flush); end
    endtask

    task automatic test_branch_mem();
        idle();
        EXMEM_MemRead = 1'b1; EXMEM_RD = 5'd5;
        IFID_Branch = 1'b1; IFID_RS = 5'd1; IFID_RT = 5'd5; IFID_UsesRT = 1'b1;
        #1;
        checks++; if ({PCWrite, IDEX_Bubble} !== 2'b01) begin errors++; $display("FAIL brmem_stall got %b want 01", {PCWrite, IDEX_Bubble}); end
        step();
        exp_stall++;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL brmem_state got %b want 00", State); end
        EXMEM_MemRead = 1'b0; EXMEM_RD = 5'd0;
        #1;
        checks++; if ({PCWrite, IDEX_Bubble, IFID_Flush} !== 3'b100) begin errors++; $display("FAIL brmem_release got %b want 100", {PCWrite, IDEX_Bubble, IFID_Flush}); end
        step();
        checks++; if (StallCount !== exp_stall) begin errors++; $display("FAIL brmem_count got %0d want %0d", StallCount, exp_stall); end
    endtask

    task automatic test_filtering();
        idle();
        IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; WriteReg = 5'd0; IFID_RS = 5'd0;
        #1;
        checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL zero_reg got %b want 1", PCWrite); end
        WriteReg = 5'd7; IFID_RS = 5'd1; IFID_RT = 5'd7; IFID_UsesRT = 1'b0;
        #1;
        checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL rt_unused got %b want 1", PCWrite); end
        IFID_UsesRT = 1'b1;
        #1;
        checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL rt_used got %b want 0", PCWrite); end
        idle();
        IDEX_RegWrite = 1'b1; WriteReg = 5'd2; IFID_Branch = 1'b1; IFID_RS = 5'd2;
        #1;
        checks++; if ({PCWrite, IDEX_Bubble} !== 2'b10) begin errors++; $display("FAIL alu_branch got %b want 10", {PCWrite, IDEX_Bubble}); end
        idle();
        step();
        checks++; if (StallCount !== exp_stall) begin errors++; $display("FAIL filter_count got %0d want %0d", StallCount, exp_stall); end
    endtask

    task automatic test_memwait_bstall();
        idle();
        IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; WriteReg = 5'd3;
        IFID_Branch = 1'b1; IFID_RS = 5'd3;
        step();
        exp_stall++;
        idle();
        IFID_Branch = 1'b1; IFID_RS = 5'd3; BranchTaken = 1'b1;
        MemWait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeHold} !== 5'b00001) begin errors++; $display("FAIL memwait_out%0d got %b want 00001", i, {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeHold}); end
            step();
            checks++; if (State !== 2'b01 || StallCount !== exp_stall) begin errors++; $display("FAIL memwait_hold%0d got %b/%0d want 01/%0d", i, State, StallCount, exp_stall); end
        end
        MemWait = 1'b0;
        #1;
        checks++; if ({PCWrite, IDEX_Bubble, IFID_Flush, PipeHold} !== 4'b0100) begin errors++; $display("FAIL memwait_stall got %b want 0100", {PCWrite, IDEX_Bubble, IFID_Flush, PipeHold}); end
        step();
        exp_stall++;
        checks++; if (State !== 2'b00 || StallCount !== exp_stall) begin errors++; $display("FAIL memwait_after got %b/%0d want 00/%0d", State, StallCount, exp_stall); end
        #1;
        checks++; if ({PCWrite, IFID_Flush} !== 2'b11) begin errors++; $display("FAIL memwait_redirect got %b want 11", {PCWrite, IFID_Flush}); end
        step();
        exp_flush++;
        idle();
    endtask

    task automatic test_jump_wrap();
        idle();
        IFID_Jump = 1'b1;
        #1;
        checks++; if ({PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble} !== 4'b1110) begin errors++; $display("FAIL jump_out got %b want 1110", {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble}); end
        while (exp_flush != 16'hFFFF) begin
            step();
            exp_flush++;
        end
        checks++; if (FlushCount !== 16'hFFFF) begin errors++; $display("FAIL flush_max got %h want ffff", FlushCount); end
        step();
        checks++; if (FlushCount !== 16'h0000) begin errors++; $display("FAIL flush_wrap got %h want 0000", FlushCount); end
        checks++; if (StallCount !== exp_stall) begin errors++; $display("FAIL jump_stalls got %0d want %0d", StallCount, exp_stall); end
        exp_flush = 16'h0000;
        idle();
    endtask

    task automatic test_reset_bstall();
        idle();
        IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; WriteReg = 5'd9;
        IFID_Branch = 1'b1; IFID_RT = 5'd9; IFID_UsesRT = 1'b1;
        step();
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL rst_pre_state got %b want 01", State); end
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if ({PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeHold} !== 5'b00110) begin errors++; $display("FAIL rst_bstall_out got %b want 00110", {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeHold}); end
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (State !== 2'b00 || StallCount !== 16'd0 || FlushCount !== 16'd0) begin errors++; $display("FAIL rst_bstall_state got %b/%0d/%0d want 00/0/0", State, StallCount, FlushCount); end
        checks++; if ({PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble} !== 4'b1100) begin errors++; $display("FAIL rst_release_out got %b want 1100", {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble}); end
        step();
        checks++; if (StallCount !== 16'd0) begin errors++; $display("FAIL rst_residual got %0d want 0", StallCount); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_mem();
        test_filtering();
        test_memwait_bstall();
        test_jump_wrap();
        test_reset_bstall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
